// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS valid/ready streams -> one registered output stream.
// Latency: request in IDLE at t -> grant at t+1; accepted beat at t -> on out_* at t+1.
// Backpressure: 2-entry skid stage; in_ready of the granted port drops only when the skid stage is full.
//
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   in_data/in_last/in_valid   per-port inputs, port i at in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready                   per-port ready, at most one bit high (the granted port)
//   out_data/out_last          registered output beat, stable while out_valid && !out_ready
//   out_valid/out_ready        output handshake
//   grant_valid/grant_idx      current grant; grant_idx holds the last granted port while idle
module stream_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 2   // ceil(log2(NUM_PORTS)), minimum 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_last,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            grant_valid,
  output logic [IDX_WIDTH-1:0]            grant_idx
);

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    SK_EMPTY,
    SK_BUSY,
    SK_FULL
  } skid_state_t;

  arb_state_t           arb_state;
  logic [IDX_WIDTH-1:0] last_grant;

  skid_state_t          skid_state;
  logic [DATA_WIDTH:0]  main_q;   // {last, data} presented on out_*
  logic [DATA_WIDTH:0]  spare_q;  // beat caught while the output is stalled

  logic                 arb_found;
  logic [IDX_WIDTH-1:0] arb_idx;
  logic                 found_hi;
  logic [IDX_WIDTH-1:0] idx_hi;
  logic                 found_lo;
  logic [IDX_WIDTH-1:0] idx_lo;

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic [DATA_WIDTH:0]   up_word;
  logic                  skid_rdy;
  logic                  up_xfer;
  logic                  dn_xfer;

  // Round-robin pick: the first requester above last_grant wins; if none,
  // wrap and take the lowest requester at or below last_grant. This makes
  // the port that just finished the lowest priority.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    found_lo = 1'b0;
    idx_lo   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i]) begin
        if (i > int'(last_grant)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = IDX_WIDTH'(i);
          end
        end else begin
          if (!found_lo) begin
            found_lo = 1'b1;
            idx_lo   = IDX_WIDTH'(i);
          end
        end
      end
    end
    arb_found = found_hi | found_lo;
    arb_idx   = found_hi ? idx_hi : idx_lo;
  end

  // Granted-port mux. Only meaningful while grant_valid is high.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == IDX_WIDTH'(i)) begin
        sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = in_last[i];
      end
    end
  end

  assign skid_rdy = (skid_state != SK_FULL);

  // Ready is built purely from registered state, never from in_valid.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = grant_valid && skid_rdy && (grant_idx == IDX_WIDTH'(i));
    end
  end

  assign up_xfer   = |(in_valid & in_ready);
  assign up_word   = {sel_last, sel_data};
  assign out_valid = (skid_state != SK_EMPTY);
  assign dn_xfer   = out_valid && out_ready;
  assign out_data  = main_q[DATA_WIDTH-1:0];
  assign out_last  = main_q[DATA_WIDTH];

  // Arbitration FSM: grant held from first beat through the last beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      arb_state   <= ARB_IDLE;
      last_grant  <= IDX_WIDTH'(NUM_PORTS - 1);
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (arb_found) begin
            arb_state   <= ARB_LOCKED;
            grant_idx   <= arb_idx;
            grant_valid <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (up_xfer && sel_last) begin
            arb_state   <= ARB_IDLE;
            last_grant  <= grant_idx;
            grant_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Skid stage: load/flow/fill/flush/unload. In FULL no upstream beat can
  // arrive (ready is low), so only the flush edge exists there.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      skid_state <= SK_EMPTY;
      main_q     <= '0;
      spare_q    <= '0;
    end else begin
      case (skid_state)
        SK_EMPTY: begin
          if (up_xfer) begin
            main_q     <= up_word;
            skid_state <= SK_BUSY;
          end
        end
        SK_BUSY: begin
          case ({up_xfer, dn_xfer})
            2'b10: begin
              spare_q    <= up_word;
              skid_state <= SK_FULL;
            end
            2'b11: main_q <= up_word;
            2'b01: skid_state <= SK_EMPTY;
            default: ;
          endcase
        end
        SK_FULL: begin
          if (dn_xfer) begin
            main_q     <= spare_q;
            skid_state <= SK_BUSY;
          end
        end
        default: skid_state <= SK_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
module tb_stream_rr_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic             clk;
  logic             reset_n;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_last;
  logic [NP-1:0]    in_valid;
  logic [NP-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic             grant_valid;
  logic [IW-1:0]    grant_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [NP-1:0] in_x;
  logic          out_x;
  logic [DW:0]   out_q [$];

  stream_rr_arbiter #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .IDX_WIDTH (IW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: sample handshakes at negedge, return 1ns after the posedge.
  task automatic cycle();
    @(negedge clk);
    in_x  = in_valid & in_ready;
    out_x = out_valid & out_ready;
    if (out_x) out_q.push_back({out_last, out_data});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    out_q.delete();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    in_data   = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++;
      if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests++;
      if (grant_valid !== 1'b0) begin fails++; $display("FAIL reset_grant_valid: got %b expected 0", grant_valid); end
      tests++;
      if (grant_idx !== 2'd0) begin fails++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    end
    reset_n = 1'b1;
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin
      fails++; $display("FAIL release_grant: got valid=%b idx=%0d expected valid=1 idx=0", grant_valid, grant_idx);
    end
    tests++;
    if (in_ready !== 4'b0001) begin fails++; $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [DW:0] exp_rot [10] = '{33'h0_00000000, 33'h1_00000001, 33'h0_00000010, 33'h1_00000011,
                                  33'h0_00000020, 33'h1_00000021, 33'h0_00000030, 33'h1_00000031,
                                  33'h0_00000000, 33'h1_00000001};
    int exp_off [8] = '{0, 1, 3, 4, 6, 7, 9, 10};
    logic [NP-1:0] beat;
    int xc_q [$];
    do_reset();
    out_ready = 1'b1;
    beat      = '0;
    in_valid  = '1;
    for (int c = 0; c < 60 && out_q.size() < 10; c++) begin
      for (int p = 0; p < NP; p++) begin
        in_data[p*DW +: DW] = 32'(p * 16) + 32'(beat[p]);
        in_last[p]          = beat[p];
      end
      tests++;
      if ($countones(in_ready) > 1) begin fails++; $display("FAIL rr_onehot: got in_ready=%b expected at most one bit", in_ready); end
      cycle();
      if (|in_x) xc_q.push_back(cyc);
      beat = beat ^ in_x;
    end
    in_valid = '0;
    tests++;
    if (out_q.size() < 10) begin
      fails++; $display("FAIL rr_count: got %0d beats expected 10", out_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        tests++;
        if (out_q[k] !== exp_rot[k]) begin
          fails++; $display("FAIL rr_beat%0d: got %h expected %h", k, out_q[k], exp_rot[k]);
        end
      end
    end
    tests++;
    if (xc_q.size() < 8) begin
      fails++; $display("FAIL rr_xfer_count: got %0d input transfers expected >= 8", xc_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        tests++;
        if (xc_q[k] - xc_q[0] !== exp_off[k]) begin
          fails++; $display("FAIL rr_rate%0d: got offset %0d expected %0d", k, xc_q[k] - xc_q[0], exp_off[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   occ = 0;
    int   sent = 0;
    int   fulls = 0;
    logic granted = 1'b0;
    logic stalled = 1'b0;
    logic [DW-1:0] held = '0;
    logic [NP-1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 60 && out_q.size() < 5; c++) begin
      in_valid[2]         = (sent < 5);
      in_data[2*DW +: DW] = 32'hA0 + 32'(sent);
      in_last[2]          = (sent == 4);
      out_ready           = (c % 3 == 0);
      exp_rdy = (granted && occ < 2) ? 4'b0100 : 4'b0000;
      if (granted && occ == 2) fulls++;
      tests++;
      if (in_ready !== exp_rdy) begin fails++; $display("FAIL bp_in_ready c%0d: got %b expected %b", c, in_ready, exp_rdy); end
      tests++;
      if (out_valid !== (occ > 0)) begin fails++; $display("FAIL bp_out_valid c%0d: got %b expected %b", c, out_valid, occ > 0); end
      if (stalled) begin
        tests++;
        if (out_data !== held) begin fails++; $display("FAIL bp_stable c%0d: got %h expected %h", c, out_data, held); end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      cycle();
      occ = occ + int'(in_x[2]) - int'(out_x);
      if (granted) begin
        if (in_x[2] && in_last[2]) granted = 1'b0;
      end else if (in_valid[2]) begin
        granted = 1'b1;
      end
      if (in_x[2]) sent++;
    end
    in_valid = '0;
    tests++;
    if (fulls == 0) begin fails++; $display("FAIL bp_full_reached: got 0 full cycles expected > 0"); end
    tests++;
    if (out_q.size() != 5) begin
      fails++; $display("FAIL bp_count: got %0d beats expected 5", out_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (out_q[k] !== {(k == 4), 32'hA0 + 32'(k)}) begin
          fails++; $display("FAIL bp_beat%0d: got %h expected %h", k, out_q[k], {(k == 4), 32'hA0 + 32'(k)});
        end
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    out_ready           = 1'b1;
    in_valid            = 4'b1010;
    in_last             = 4'b1010;
    in_data[1*DW +: DW] = 32'h11;
    in_data[3*DW +: DW] = 32'h33;
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd1 || in_ready !== 4'b0010) begin
      fails++; $display("FAIL prio_first: got gv=%b idx=%0d rdy=%b expected gv=1 idx=1 rdy=0010", grant_valid, grant_idx, in_ready);
    end
    cycle();
    tests++;
    if (grant_valid !== 1'b0 || in_ready !== 4'b0000) begin
      fails++; $display("FAIL prio_idle: got gv=%b rdy=%b expected gv=0 rdy=0000", grant_valid, in_ready);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h11 || out_last !== 1'b1) begin
      fails++; $display("FAIL prio_out1: got v=%b d=%h l=%b expected v=1 d=11 l=1", out_valid, out_data, out_last);
    end
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd3 || in_ready !== 4'b1000) begin
      fails++; $display("FAIL prio_next: got gv=%b idx=%0d rdy=%b expected gv=1 idx=3 rdy=1000", grant_valid, grant_idx, in_ready);
    end
    cycle();
    tests++;
    if (grant_valid !== 1'b0 || grant_idx !== 2'd3) begin
      fails++; $display("FAIL prio_hold_idx: got gv=%b idx=%0d expected gv=0 idx=3", grant_valid, grant_idx);
    end
    tests++;
    if (out_data !== 32'h33) begin fails++; $display("FAIL prio_out3: got %h expected 33", out_data); end
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin
      fails++; $display("FAIL prio_wrap: got gv=%b idx=%0d expected gv=1 idx=1", grant_valid, grant_idx);
    end
    in_valid = '0;
  endtask

  task automatic test_stall_mid_packet();
    logic [DW:0] exp_st [5] = '{33'h0_000000B0, 33'h0_000000B1, 33'h0_000000B2, 33'h1_000000B3, 33'h1_000000C0};
    do_reset();
    out_ready           = 1'b1;
    in_valid            = 4'b0100;
    in_last             = 4'b0000;
    in_data[2*DW +: DW] = 32'hB0;
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd2 || in_ready !== 4'b0100) begin
      fails++; $display("FAIL stall_grant: got gv=%b idx=%0d rdy=%b expected gv=1 idx=2 rdy=0100", grant_valid, grant_idx, in_ready);
    end
    cycle();
    in_data[2*DW +: DW] = 32'hB1;
    cycle();
    in_valid            = 4'b0001;
    in_last[0]          = 1'b1;
    in_data[0*DW +: DW] = 32'hC0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      tests++;
      if (grant_valid !== 1'b1 || grant_idx !== 2'd2 || in_ready !== 4'b0100) begin
        fails++; $display("FAIL stall_hold c%0d: got gv=%b idx=%0d rdy=%b expected gv=1 idx=2 rdy=0100", c, grant_valid, grant_idx, in_ready);
      end
    end
    in_valid[2]         = 1'b1;
    in_data[2*DW +: DW] = 32'hB2;
    cycle();
    in_data[2*DW +: DW] = 32'hB3;
    in_last[2]          = 1'b1;
    cycle();
    in_valid[2] = 1'b0;
    tests++;
    if (grant_valid !== 1'b0) begin fails++; $display("FAIL stall_release: got gv=%b expected 0", grant_valid); end
    cycle();
    tests++;
    if (grant_valid !== 1'b1 || grant_idx !== 2'd0 || in_ready !== 4'b0001) begin
      fails++; $display("FAIL stall_next: got gv=%b idx=%0d rdy=%b expected gv=1 idx=0 rdy=0001", grant_valid, grant_idx, in_ready);
    end
    cycle();
    in_valid = '0;
    for (int c = 0; c < 3; c++) cycle();
    tests++;
    if (out_q.size() != 5) begin
      fails++; $display("FAIL stall_count: got %0d beats expected 5", out_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++;
        if (out_q[k] !== exp_st[k]) begin
          fails++; $display("FAIL stall_beat%0d: got %h expected %h", k, out_q[k], exp_st[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready           = 1'b0;
    in_valid            = 4'b0001;
    in_data[0*DW +: DW] = 32'hE0;
    cycle();
    cycle();
    in_data[0*DW +: DW] = 32'hE1;
    cycle();
    tests++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'hE0) begin
      fails++; $display("FAIL rmp_full: got rdy=%b v=%b d=%h expected rdy=0000 v=1 d=E0", in_ready, out_valid, out_data);
    end
    reset_n  = 1'b0;
    in_valid = '0;
    cycle();
    reset_n = 1'b1;
    tests++;
    if (out_valid !== 1'b0 || grant_valid !== 1'b0 || in_ready !== 4'b0000) begin
      fails++; $display("FAIL rmp_cleared: got v=%b gv=%b rdy=%b expected v=0 gv=0 rdy=0000", out_valid, grant_valid, in_ready);
    end
    out_q.delete();
    out_ready           = 1'b1;
    in_valid            = 4'b0010;
    in_last             = 4'b0010;
    in_data[1*DW +: DW] = 32'hD1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (in_x[1]) in_valid[1] = 1'b0;
    end
    tests++;
    if (out_q.size() != 1) begin
      fails++; $display("FAIL rmp_count: got %0d beats expected 1", out_q.size());
    end else begin
      tests++;
      if (out_q[0] !== 33'h1_000000D1) begin fails++; $display("FAIL rmp_beat: got %h expected 1000000d1", out_q[0]); end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    in_x      = '0;
    out_x     = 1'b0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_priority();
    test_stall_mid_packet();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one valid/ready output stream between NUM_PORTS valid/ready input streams using packet-granular round-robin arbitration.
- A grant is held from the first beat through the beat carrying in_last, so packets never interleave.
- The output passes through an internal 2-entry skid stage, so out_valid/out_data are registered and the block sustains 1 beat/cycle within a packet.
- Sits in front of shared AXI-Stream consumers: DMA write channel, shared response path, debug UART.

Parameters:
- NUM_PORTS, 4, number of requesters (2..16).
- DATA_WIDTH, 32, payload width per beat.
- IDX_WIDTH, 2, width of grant_idx; must equal ceil(log2(NUM_PORTS)), minimum 1.

Ports:
- clk  in  1  single clock; all logic rises on posedge.
- reset_n  in  1  synchronous, active-low reset.
- in_data  in  NUM_PORTS*DATA_WIDTH  packed payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_PORTS  per-port end-of-packet flag.
- in_valid  in  NUM_PORTS  per-port valid.
- in_ready  out  NUM_PORTS  per-port ready; at most one bit is high.
- out_data  out  DATA_WIDTH  arbitrated payload, registered.
- out_last  out  1  end-of-packet, registered alongside out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- grant_valid  out  1  high while a port holds the grant (LOCKED state).
- grant_idx  out  IDX_WIDTH  index of the granted port; last granted index while idle.

Behaviour:
- **Reset** (reset_n=0 at posedge): state=IDLE, last_grant=NUM_PORTS-1, grant_idx=0, grant_valid=0, in_ready=0, out_valid=0, skid stage EMPTY. Reset mid-packet discards any buffered beats and drops the grant; there is no partial-packet recovery.
- **Handshake rules:**
  - Input transfer on port i = in_valid[i] && in_ready[i].
  - Output transfer = out_valid && out_ready.
  - Once out_valid=1, out_data and out_last stay stable until the output transfer.
  - in_ready never depends combinationally on in_valid.
- **FSM:**
  - IDLE:
    - in_ready=0 on all ports.
    - If any in_valid bit is set, select g = first set index scanning (last_grant+1) mod NUM_PORTS upward with wrap.
    - Next cycle: state=LOCKED, grant_idx=g, grant_valid=1.
    - If no in_valid bit is set, stay in IDLE.
  - LOCKED:
    - in_ready[grant_idx] = skid stage not FULL; all other in_ready bits are 0.
    - On an input transfer with in_last=1: next cycle state=IDLE, last_grant=grant_idx, grant_valid=0.
    - Transfers without last keep the state.
    - Dropping in_valid mid-packet keeps the grant indefinitely; there is no timeout.
- **Skid stage:**
  - States EMPTY/BUSY/FULL with edges load/flow/fill/flush/unload, identical semantics to the team skid buffer.
  - Width is DATA_WIDTH+1 (data plus last).
  - out_valid = state != EMPTY.
  - Upstream ready = state != FULL.
  - Implemented in this block so that reset_n clears it.
- **Latency:**
  - A beat accepted at cycle t appears on out_* at t+1 if the output is empty or draining.
  - Arbitration overhead: a request seen in IDLE at cycle t is granted at t+1, and its first beat can be accepted at t+1.
  - After the last beat is accepted at t, the block is IDLE at t+1 and the next grant is at t+2. This gives one idle input cycle per packet boundary; output bubbles hide it when out_ready stalls.
- **Fairness:**
  - A port that has just finished a packet has lowest priority at the next arbitration.
  - With all ports continuously requesting, grants cycle 0,1,2,...,NUM_PORTS-1,0.
- **Simultaneous events:**
  - A last-beat transfer and a new request from another port in the same cycle: the new request is evaluated in the following IDLE cycle using the updated last_grant.
  - Output drain and input accept in the same cycle are handled by the flow/flush edges; no beat is lost or duplicated.
- **Single-beat packets** (in_last=1 on the first beat) are legal.
- **NUM_PORTS=1** degenerates to a skid buffer with a 1-cycle grant bubble per packet.

Test Plan:
- **Reset defaults:** hold reset_n=0 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, grant_valid=0, grant_idx=0. Release -> grant_idx=0 one cycle later.
- **Round-robin rotation:** NUM_PORTS=4, all ports continuously send 2-beat packets (data=port*16+beat), out_ready=1 -> packets emerge in port order 0,1,2,3,0 with no interleaving. Sustained rate is 2 beats per 3 cycles.
- **Backpressure:** port 2 sends a 5-beat packet 0xA0..0xA4 while out_ready toggles 1,0,0,1,... -> out sequence is exactly A0..A4, with out_last only on A4. in_ready[2] drops only when the skid stage is FULL; out_data is stable while stalled.
- **Priority after completion:** ports 1 and 3 request and port 1 finishes a packet -> next grant is port 3, even if port 1 re-asserts in_valid immediately.
- **Stall mid-packet:** the granted port deasserts in_valid for 10 cycles mid-packet while port 0 requests -> grant_idx is unchanged and port 0 is never ready until the granted port's last beat transfers.
- **Reset mid-packet:** pulse reset_n low for 1 cycle while the skid stage is FULL -> next cycle out_valid=0, grant_valid=0, and no stale beat is emitted afterward.
